// File: rtl/raiz_pkg.sv
// Shared types and helpers for the raiz square-root datapath.
package raiz_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ITER = 2'b01,
        S_DONE = 2'b10
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned bits;
        int unsigned span;
        bits = 0;
        span = 1;
        while (span < v) begin
            span = span << 1;
            bits++;
        end
        return bits;
    endfunction

endpackage

// File: rtl/raiz_step.sv
// One restoring square-root iteration: trial subtract of {q,01} from the
// shifted remainder, keep or restore, and append one root bit.
module raiz_step #(
    parameter int unsigned N = 8
) (
    input  logic [N:0]   r,
    input  logic [N-1:0] q,
    input  logic [1:0]   pair,
    output logic [N:0]   r_nxt,
    output logic [N-1:0] q_nxt
);

    logic [N+1:0] t;

    // r[N] is only ever set by the final step, so it never feeds a trial.
    logic unused_r_msb;
    assign unused_r_msb = r[N];

    // On a restore r <= q < 2**(N-1), so dropping r[N-1] loses nothing.
    always_comb begin
        t = {r[N-1:0], pair} - {q, 2'b01};
        if (!t[N+1]) begin
            r_nxt = t[N:0];
            q_nxt = {q[N-2:0], 1'b1};
        end else begin
            r_nxt = {1'b0, r[N-2:0], pair};
            q_nxt = {q[N-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/raiz_param.sv
// Parametrised integer square root: floor(sqrt(R)) and R - root^2,
// one root bit per clock, with an init/done 4-phase handshake.
module raiz_param
    import raiz_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_init,
    input  logic [WIDTH-1:0]     in_RADICAND,
    output logic [WIDTH/2-1:0]   out_ROOT,
    output logic [WIDTH/2:0]     out_REM,
    output logic                 out_BUSY,
    output logic                 out_DONE
);

    localparam int unsigned N  = WIDTH / 2;
    localparam int unsigned CW = clog2(N);

    state_t         state, state_nxt;
    logic [WIDTH-1:0] x;
    logic [N-1:0]   q, q_nxt;
    logic [N:0]     r, r_nxt;
    logic [CW-1:0]  cnt;
    logic           last;

    raiz_step #(.N(N)) u_step (
        .r     (r),
        .q     (q),
        .pair  (x[WIDTH-1:WIDTH-2]),
        .r_nxt (r_nxt),
        .q_nxt (q_nxt)
    );

    assign last     = (state == S_ITER) && (cnt == CW'(N - 1));
    assign out_BUSY = (state == S_ITER);
    assign out_DONE = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:  state_nxt = in_init ? S_ITER : S_IDLE;
            S_ITER:  state_nxt = last ? S_DONE : S_ITER;
            S_DONE:  state_nxt = in_init ? S_DONE : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x        <= '0;
            q        <= '0;
            r        <= '0;
            cnt      <= '0;
            out_ROOT <= '0;
            out_REM  <= '0;
        end else begin
            if (state == S_IDLE && in_init) begin
                x   <= in_RADICAND;
                q   <= '0;
                r   <= '0;
                cnt <= '0;
            end else if (state == S_ITER) begin
                x <= {x[WIDTH-3:0], 2'b00};
                q <= q_nxt;
                r <= r_nxt;
                // Counter parks at N-1; the next accept reloads it.
                if (last) begin
                    out_ROOT <= q_nxt;
                    out_REM  <= r_nxt;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_raiz_param.sv
// Scoreboard bench for raiz_param at WIDTH=16 and WIDTH=8.
module tb_raiz_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        init16, init8;
    logic [15:0] rad16;
    logic [7:0]  rad8;
    logic [7:0]  root16;
    logic [8:0]  rem16;
    logic [3:0]  root8;
    logic [4:0]  rem8;
    logic        busy16, done16, busy8, done8;

    raiz_param #(.WIDTH(16)) dut16 (
        .clk         (clk),
        .rst         (rst),
        .in_init     (init16),
        .in_RADICAND (rad16),
        .out_ROOT    (root16),
        .out_REM     (rem16),
        .out_BUSY    (busy16),
        .out_DONE    (done16)
    );

    raiz_param #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .in_init     (init8),
        .in_RADICAND (rad8),
        .out_ROOT    (root8),
        .out_REM     (rem8),
        .out_BUSY    (busy8),
        .out_DONE    (done8)
    );

    typedef struct {
        int unsigned root;
        int unsigned rem;
    } exp_t;

    exp_t sb16[$];
    exp_t sb8[$];
    int checks = 0;
    int errors = 0;
    int unsigned ndone16 = 0;
    int unsigned ndone8  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned isqrt(input int unsigned v);
        int unsigned k;
        k = 0;
        while ((k + 1) * (k + 1) <= v) k++;
        return k;
    endfunction

    function automatic exp_t model(input int unsigned v);
        exp_t e;
        e.root = isqrt(v);
        e.rem  = v - e.root * e.root;
        return e;
    endfunction

    // Monitors pop the scoreboard on each rising edge of out_DONE.
    logic done16_q = 1'b0;
    logic done8_q  = 1'b0;

    always @(posedge clk) begin : mon16
        exp_t e;
        #1;
        if (done16 && !done16_q) begin
            ndone16++;
            if (sb16.size() == 0) check("done16_unexpected", 32'd1, 32'd0);
            else begin
                e = sb16.pop_front();
                check("root16", 32'(root16), e.root);
                check("rem16", 32'(rem16), e.rem);
            end
        end
        done16_q = done16;
    end

    always @(posedge clk) begin : mon8
        exp_t e;
        #1;
        if (done8 && !done8_q) begin
            ndone8++;
            if (sb8.size() == 0) check("done8_unexpected", 32'd1, 32'd0);
            else begin
                e = sb8.pop_front();
                check("root8", 32'(root8), e.root);
                check("rem8", 32'(rem8), e.rem);
            end
        end
        done8_q = done8;
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic run_op(input bit w8, input int unsigned v, input int unsigned exp_lat);
        int unsigned lat;
        int unsigned busyc;
        if (w8) begin
            rad8 = 8'(v); init8 = 1'b1; sb8.push_back(model(v));
        end else begin
            rad16 = 16'(v); init16 = 1'b1; sb16.push_back(model(v));
        end
        tick;
        init8  = 1'b0;
        init16 = 1'b0;
        lat   = 0;
        busyc = 0;
        while (!(w8 ? done8 : done16) && lat < 40) begin
            if (w8 ? busy8 : busy16) busyc++;
            tick;
            lat++;
        end
        check(w8 ? "latency8" : "latency16", lat, exp_lat);
        check(w8 ? "busy8_cycles" : "busy16_cycles", busyc, exp_lat);
        tick;
        check(w8 ? "done8_drop" : "done16_drop", 32'(w8 ? done8 : done16), 32'd0);
        check(w8 ? "hold_root8" : "hold_root16", 32'(w8 ? root8 : root16), isqrt(v));
    endtask

    initial begin : main
        int unsigned n0;
        int unsigned lat;
        int unsigned order [256];
        int unsigned j, tmp;

        rst = 1'b1; init16 = 1'b0; init8 = 1'b0; rad16 = '0; rad8 = '0;
        tick;
        tick;
        rst = 1'b0;
        check("rst_root16", 32'(root16), 32'd0);
        check("rst_rem16", 32'(rem16), 32'd0);
        check("rst_busy16", 32'(busy16), 32'd0);
        check("rst_done16", 32'(done16), 32'd0);
        check("rst_root8", 32'(root8), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);

        run_op(1'b0, 144, 8);
        run_op(1'b0, 0, 8);
        run_op(1'b0, 65535, 8);
        run_op(1'b0, 2, 8);

        // init held high: exactly one computation
        n0 = ndone16;
        rad16 = 16'd50; init16 = 1'b1; sb16.push_back(model(50));
        repeat (20) tick;
        check("held_done", 32'(done16), 32'd1);
        check("held_ndone", ndone16 - n0, 32'd1);
        init16 = 1'b0;
        tick;
        check("held_idle_done", 32'(done16), 32'd0);
        check("held_idle_busy", 32'(busy16), 32'd0);

        // re-request mid-ITER with new operand is ignored
        n0 = ndone16;
        rad16 = 16'd1000; init16 = 1'b1; sb16.push_back(model(1000));
        tick;
        init16 = 1'b0;
        tick;
        tick;
        rad16 = 16'd9; init16 = 1'b1;
        tick;
        init16 = 1'b0;
        lat = 0;
        while (!done16 && lat < 20) begin tick; lat++; end
        check("mid_done_seen", 32'(done16), 32'd1);
        tick;
        tick;
        check("mid_no_restart", 32'(busy16), 32'd0);
        check("mid_ndone", ndone16 - n0, 32'd1);

        // reset during the 4th ITER cycle discards the computation
        rad16 = 16'd1000; init16 = 1'b1;
        tick;
        init16 = 1'b0;
        tick;
        tick;
        tick;
        check("pre_rst_busy", 32'(busy16), 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("midrst_root", 32'(root16), 32'd0);
        check("midrst_rem", 32'(rem16), 32'd0);
        check("midrst_busy", 32'(busy16), 32'd0);
        check("midrst_done", 32'(done16), 32'd0);
        tick;
        check("midrst_idle", 32'(busy16), 32'd0);
        run_op(1'b0, 81, 8);

        run_op(1'b1, 200, 4);
        for (int unsigned i = 0; i < 256; i++) order[i] = i;
        for (int unsigned i = 255; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        for (int unsigned i = 0; i < 256; i++) run_op(1'b1, order[i], 4);

        tick;
        check("sb16_drain", sb16.size(), 32'd0);
        check("sb8_drain", sb8.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
